uart_ctrl: RTL and testbench

- Bus-facing controller that sits between the 6502 system bus and the UART core.
- Buffers outgoing bytes in a TX FIFO and sequences them into the UART's tx_write / tx_finished handshake, one byte at a time.
- Captures received bytes from the UART's rx_ready pulses into an RX FIFO.
- Exposes data, status and control registers plus a level-sensitive IRQ.

---
 rtl/uart_ctrl_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_ctrl.sv | 148 ++++++++++++++
 tb/tb_uart_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART bus controller: register map, STATUS/CONTROL
// bit positions and the TX sequencer state encoding.
package uart_ctrl_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_RX_AVAIL    = 0;
  localparam int ST_TX_SPACE    = 1;
  localparam int ST_TX_IDLE     = 2;
  localparam int ST_RX_OVERRUN  = 3;
  localparam int ST_TX_OVERFLOW = 4;
  localparam int ST_IRQ         = 7;

  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_TX_IRQ_EN = 1;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO of 2**FIFO_AW entries. A push into a full FIFO is
// accepted when a real pop happens in the same cycle; pops on empty are ignored.
module sync_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_din,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int                 DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_MAX = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_pop_ok;
  logic               w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_MAX);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// 6502-bus register front end for a UART core: TX/RX byte FIFOs, a two-state
// transmit sequencer driving the tx_write/tx_finished handshake, sticky error flags and IRQ.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rw,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  output logic       u_tx_write,
  output logic [7:0] u_tx_data,
  input  logic       u_tx_finished,
  input  logic       u_rx_ready,
  input  logic [7:0] u_rx_data,
  output logic       o_tx_state
);

  tx_state_t  r_state;
  tx_state_t  w_next;
  logic       r_tx_write;
  logic [7:0] r_tx_data;
  logic [1:0] r_ctrl;
  logic       r_rx_overrun;
  logic       r_tx_overflow;
  logic       r_irq;

  logic       w_wr, w_rd;
  logic       w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [7:0] w_tx_head;
  logic       w_rx_pop, w_rx_full, w_rx_empty, w_rx_push_ok;
  logic [7:0] w_rx_head;
  logic       w_tx_idle;
  logic       w_ovf_set, w_ovf_clr, w_ovr_set, w_ovr_clr;
  logic [7:0] w_status;

  assign w_wr      = cs & ~rw;
  assign w_rd      = cs & rw;
  assign w_tx_push = w_wr & (addr == REG_DATA);
  assign w_rx_pop  = w_rd & (addr == REG_DATA);
  assign w_tx_idle = w_tx_empty & (r_state == TX_IDLE);

  sync_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_din   (din),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  sync_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (u_rx_ready),
    .i_pop   (w_rx_pop),
    .i_din   (u_rx_data),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // Mirrors the FIFO acceptance rule so a drop can be flagged in the same cycle.
  assign w_rx_push_ok = ~w_rx_full | (w_rx_pop & ~w_rx_empty);

  assign w_ovf_set = w_tx_push & w_tx_full & ~w_tx_pop;
  assign w_ovf_clr = w_wr & (addr == REG_STATUS) & din[ST_TX_OVERFLOW];
  assign w_ovr_set = u_rx_ready & ~w_rx_push_ok;
  assign w_ovr_clr = w_wr & (addr == REG_STATUS) & din[ST_RX_OVERRUN];

  always_comb begin
    w_next   = r_state;
    w_tx_pop = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (!w_tx_empty) begin
          w_tx_pop = 1'b1;
          w_next   = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (u_tx_finished) w_next = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= TX_IDLE;
      r_tx_write <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_next;
      r_tx_write <= w_tx_pop;
      if (w_tx_pop) r_tx_data <= w_tx_head;
    end
  end

  // Sticky flags: a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl        <= 2'b00;
      r_rx_overrun  <= 1'b0;
      r_tx_overflow <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      if (w_wr && addr == REG_CTRL) r_ctrl <= din[1:0];
      r_rx_overrun  <= w_ovr_set | (r_rx_overrun & ~w_ovr_clr);
      r_tx_overflow <= w_ovf_set | (r_tx_overflow & ~w_ovf_clr);
      r_irq <= (r_ctrl[CTRL_RX_IRQ_EN] & ~w_rx_empty)
             | (r_ctrl[CTRL_TX_IRQ_EN] & w_tx_idle)
             | r_rx_overrun;
    end
  end

  always_comb begin
    w_status                 = 8'h00;
    w_status[ST_RX_AVAIL]    = ~w_rx_empty;
    w_status[ST_TX_SPACE]    = ~w_tx_full;
    w_status[ST_TX_IDLE]     = w_tx_idle;
    w_status[ST_RX_OVERRUN]  = r_rx_overrun;
    w_status[ST_TX_OVERFLOW] = r_tx_overflow;
    w_status[ST_IRQ]         = r_irq;
  end

  always_comb begin
    dout = 8'h00;
    case (addr)
      REG_DATA:   dout = w_rx_empty ? 8'h00 : w_rx_head;
      REG_STATUS: dout = w_status;
      REG_CTRL:   dout = {6'b0, r_ctrl};
      default:    dout = 8'h00;
    endcase
  end

  assign irq        = r_irq;
  assign u_tx_write = r_tx_write;
  assign u_tx_data  = r_tx_data;
  assign o_tx_state = r_state;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: bus accesses and UART pulses are driven just
// after each posedge; outputs are sampled 1-2 ns after the edge.
module tb_uart_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b0;
  logic       rw = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       irq;
  logic       u_tx_write;
  logic [7:0] u_tx_data;
  logic       u_tx_finished = 1'b0;
  logic       u_rx_ready = 1'b0;
  logic [7:0] u_rx_data = 8'h00;
  logic       o_tx_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_ctrl #(.FIFO_AW(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .cs            (cs),
    .rw            (rw),
    .addr          (addr),
    .din           (din),
    .dout          (dout),
    .irq           (irq),
    .u_tx_write    (u_tx_write),
    .u_tx_data     (u_tx_data),
    .u_tx_finished (u_tx_finished),
    .u_rx_ready    (u_rx_ready),
    .u_rx_data     (u_rx_data),
    .o_tx_state    (o_tx_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; addr = a; din = d;
    tick();
    cs = 1'b0; rw = 1'b1; din = 8'h00;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; rw = 1'b1; addr = a;
    #1 d = dout;
    tick();
    cs = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    u_rx_ready = 1'b1; u_rx_data = b;
    tick();
    u_rx_ready = 1'b0; u_rx_data = 8'h00;
  endtask

  task automatic tx_finish();
    u_tx_finished = 1'b1;
    tick();
    u_tx_finished = 1'b0;
  endtask

  task automatic wait_tx_pulse(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (u_tx_write) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
    n_checks++; if (u_tx_write !== 1'b0) begin n_fail++; $display("FAIL reset_tx_write got=%b exp=0", u_tx_write); end
    n_checks++; if (u_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got=%h exp=00", u_tx_data); end
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h06) begin n_fail++; $display("FAIL reset_status got=%h exp=06", d); end
    bus_read(2'd2, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=00", d); end
  endtask

  task automatic test_tx_basic();
    logic [7:0] d;
    bus_write(2'd0, 8'h41);
    bus_write(2'd0, 8'h42);
    n_checks++; if ({u_tx_write, u_tx_data} !== {1'b1, 8'h41}) begin n_fail++; $display("FAIL tx_first_pulse got=%b/%h exp=1/41", u_tx_write, u_tx_data); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if ({u_tx_write, u_tx_data} !== {1'b0, 8'h41}) begin n_fail++; $display("FAIL tx_busy_hold got=%b/%h exp=0/41", u_tx_write, u_tx_data); end
    end
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL tx_busy_status got=%h exp=02", d); end
    tx_finish();
    n_checks++; if (u_tx_write !== 1'b0) begin n_fail++; $display("FAIL tx_gap_after_finish got=%b exp=0", u_tx_write); end
    tick();
    n_checks++; if ({u_tx_write, u_tx_data} !== {1'b1, 8'h42}) begin n_fail++; $display("FAIL tx_second_pulse got=%b/%h exp=1/42", u_tx_write, u_tx_data); end
    tick();
    tx_finish();
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h06) begin n_fail++; $display("FAIL tx_done_status got=%h exp=06", d); end
  endtask

  task automatic test_tx_overflow();
    logic [7:0] d;
    bit seen;
    // One byte goes straight into flight, leaving exactly eight to fill the FIFO.
    for (int i = 0; i < 9; i++) bus_write(2'd0, 8'(8'h60 + i));
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL ovf_full_status got=%h exp=00", d); end
    bus_write(2'd0, 8'h69);
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h10) begin n_fail++; $display("FAIL ovf_flag_status got=%h exp=10", d); end
    bus_write(2'd1, 8'h10);
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL ovf_clear_status got=%h exp=00", d); end
    n_checks++; if (u_tx_data !== 8'h60) begin n_fail++; $display("FAIL ovf_inflight got=%h exp=60", u_tx_data); end
    tx_finish();
    for (int i = 1; i < 9; i++) begin
      wait_tx_pulse(seen);
      n_checks++; if (!seen) begin n_fail++; $display("FAIL ovf_drain_timeout idx=%0d got=none exp=pulse", i); end
      n_checks++; if (u_tx_data !== 8'(8'h60 + i)) begin n_fail++; $display("FAIL ovf_drain_data got=%h exp=%h", u_tx_data, 8'(8'h60 + i)); end
      tick();
      tx_finish();
    end
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h06) begin n_fail++; $display("FAIL ovf_drained_status got=%h exp=06", d); end
  endtask

  task automatic test_rx_basic();
    logic [7:0] d;
    rx_push(8'h55);
    rx_push(8'hAA);
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h07) begin n_fail++; $display("FAIL rx_avail_status got=%h exp=07", d); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rx_irq_masked got=%b exp=0", irq); end
    bus_read(2'd0, d);
    n_checks++; if (d !== 8'h55) begin n_fail++; $display("FAIL rx_read1 got=%h exp=55", d); end
    bus_read(2'd0, d);
    n_checks++; if (d !== 8'hAA) begin n_fail++; $display("FAIL rx_read2 got=%h exp=AA", d); end
    bus_read(2'd0, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rx_read_empty got=%h exp=00", d); end
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h06) begin n_fail++; $display("FAIL rx_empty_status got=%h exp=06", d); end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] d;
    for (int i = 0; i < 9; i++) rx_push(8'(8'h80 + i));
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ovr_irq_lag got=%b exp=0", irq); end
    tick();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ovr_irq got=%b exp=1", irq); end
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h8F) begin n_fail++; $display("FAIL ovr_status got=%h exp=8F", d); end
    bus_write(2'd1, 8'h08);
    tick();
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h07) begin n_fail++; $display("FAIL ovr_clear_status got=%h exp=07", d); end
    cs = 1'b1; rw = 1'b1; addr = 2'd0; u_rx_ready = 1'b1; u_rx_data = 8'h99;
    #1 d = dout;
    tick();
    cs = 1'b0; u_rx_ready = 1'b0; u_rx_data = 8'h00;
    n_checks++; if (d !== 8'h80) begin n_fail++; $display("FAIL ovr_pop_push_head got=%h exp=80", d); end
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h07) begin n_fail++; $display("FAIL ovr_pop_push_status got=%h exp=07", d); end
    for (int i = 1; i < 8; i++) begin
      bus_read(2'd0, d);
      n_checks++; if (d !== 8'(8'h80 + i)) begin n_fail++; $display("FAIL ovr_order got=%h exp=%h", d, 8'(8'h80 + i)); end
    end
    bus_read(2'd0, d);
    n_checks++; if (d !== 8'h99) begin n_fail++; $display("FAIL ovr_late_byte got=%h exp=99", d); end
    bus_read(2'd0, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL ovr_final_empty got=%h exp=00", d); end
  endtask

  task automatic test_tx_irq();
    logic [7:0] d;
    bus_write(2'd2, 8'h02);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL txirq_lag got=%b exp=0", irq); end
    tick();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL txirq_idle got=%b exp=1", irq); end
    bus_read(2'd2, d);
    n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL txirq_ctrl_read got=%h exp=02", d); end
    bus_write(2'd0, 8'h33);
    tick();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL txirq_fall got=%b exp=0", irq); end
    n_checks++; if ({u_tx_write, u_tx_data} !== {1'b1, 8'h33}) begin n_fail++; $display("FAIL txirq_pulse got=%b/%h exp=1/33", u_tx_write, u_tx_data); end
    tick();
    tx_finish();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL txirq_rise_lag got=%b exp=0", irq); end
    tick();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL txirq_rise got=%b exp=1", irq); end
  endtask

  task automatic test_reset_busy();
    logic [7:0] d;
    bus_write(2'd0, 8'h34);
    bus_write(2'd0, 8'h35);
    rx_push(8'h77);
    n_checks++; if (o_tx_state !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy got=%b exp=1", o_tx_state); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if ({o_tx_state, u_tx_write, u_tx_data} !== {1'b0, 1'b0, 8'h00}) begin n_fail++; $display("FAIL rst_outputs got=%b/%b/%h exp=0/0/00", o_tx_state, u_tx_write, u_tx_data); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b exp=0", irq); end
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h06) begin n_fail++; $display("FAIL rst_status got=%h exp=06", d); end
    bus_read(2'd0, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_rx_empty got=%h exp=00", d); end
    tx_finish();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({o_tx_state, u_tx_write} !== 2'b00) begin n_fail++; $display("FAIL rst_stray_finish got=%b/%b exp=0/0", o_tx_state, u_tx_write); end
    end
    bus_write(2'd0, 8'h36);
    tick();
    n_checks++; if ({u_tx_write, u_tx_data} !== {1'b1, 8'h36}) begin n_fail++; $display("FAIL rst_next_pulse got=%b/%h exp=1/36", u_tx_write, u_tx_data); end
    tick(); tick();
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL rst_next_busy got=%h exp=02", d); end
    tx_finish();
    bus_read(2'd1, d);
    n_checks++; if (d !== 8'h06) begin n_fail++; $display("FAIL rst_next_done got=%h exp=06", d); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx_basic();
    test_rx_overrun();
    test_tx_irq();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
